scroll_display_ctrl: RTL and testbench

Sequencer for the 4-digit multiplexed seven-segment display. It holds a writable message buffer of up to 16 segment patterns and time-multiplexes the four digit enables. It scrolls the message right-to-left across the display at a programmable rate, either looping or running once. It sits between the host/config logic that loads text and the board's `digit`/`sseg`/`dp` pins.

---
 rtl/scroll_display_ctrl.sv | 166 ++++++++++++++++
 tb/tb_scroll_display_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_display_ctrl.sv
// Four-digit multiplexed seven-segment sequencer that scrolls a message of up to 16
// segment patterns right-to-left, looping or running once.
module scroll_display_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [6:0] wr_data,
  input  logic [4:0] msg_len,
  input  logic       one_shot,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  output logic [3:0] digit,
  output logic [6:0] sseg,
  output logic       dp,
  output logic       busy,
  output logic       wrap,
  output logic       done
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(SCROLL_DIV - 1);
  localparam logic [6:0]    BLANK    = 7'b1111111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      len_reg, len_next;
  logic            one_shot_reg, one_shot_next;
  logic [4:0]      offset_reg, offset_next;
  logic [1:0]      pos_reg, pos_next;
  logic [FW-1:0]   frame_reg, frame_next;
  logic [RW-1:0]   refresh_reg, refresh_next;
  logic [3:0]      digit_reg, digit_next;
  logic [6:0]      sseg_reg, sseg_next;
  logic            wrap_reg, wrap_next;
  logic            done_reg, done_next;
  logic [6:0]      buf_reg [16];

  logic            start_ok;
  logic            ref_tc;
  logic            frame_wrap;
  logic [5:0]      seq_sum;
  logic [5:0]      seq_idx;

  assign start_ok   = start && !stop && (msg_len != 5'd0) && (msg_len <= 5'd16);
  assign ref_tc     = (refresh_reg == REF_LAST);
  assign frame_wrap = ref_tc && (pos_reg == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) buf_reg[i] <= BLANK;
    end else if (wr_en) begin
      buf_reg[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      len_reg      <= 5'd0;
      one_shot_reg <= 1'b0;
      offset_reg   <= 5'd0;
      pos_reg      <= 2'd0;
      frame_reg    <= '0;
      refresh_reg  <= '0;
      digit_reg    <= 4'b1111;
      sseg_reg     <= BLANK;
      wrap_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      one_shot_reg <= one_shot_next;
      offset_reg   <= offset_next;
      pos_reg      <= pos_next;
      frame_reg    <= frame_next;
      refresh_reg  <= refresh_next;
      digit_reg    <= digit_next;
      sseg_reg     <= sseg_next;
      wrap_reg     <= wrap_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    one_shot_next = one_shot_reg;
    offset_next   = offset_reg;
    pos_next      = pos_reg;
    frame_next    = frame_reg;
    refresh_next  = refresh_reg;
    wrap_next     = 1'b0;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next    = RUN;
          len_next      = msg_len + 5'd4;
          one_shot_next = one_shot;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else begin
          refresh_next = ref_tc ? '0 : refresh_reg + 1'b1;
          if (ref_tc) pos_next = pos_reg + 2'd1;
          // While paused the frame count parks at its last value so the step
          // fires on the first frame wrap after release.
          if (frame_wrap) begin
            if (frame_reg != FRM_LAST) begin
              frame_next = frame_reg + 1'b1;
            end else if (!pause) begin
              frame_next = '0;
              if (offset_reg == len_reg - 5'd1) begin
                offset_next = 5'd0;
                wrap_next   = 1'b1;
                if (one_shot_reg) begin
                  done_next  = 1'b1;
                  state_next = IDLE;
                end
              end else begin
                offset_next = offset_reg + 5'd1;
              end
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == IDLE) begin
      offset_next  = 5'd0;
      pos_next     = 2'd0;
      frame_next   = '0;
      refresh_next = '0;
    end
  end

  // Outputs are computed from next-state position so digit and sseg move together.
  always_comb begin
    seq_sum    = {1'b0, offset_next} + {4'b0, pos_next};
    seq_idx    = (seq_sum >= {1'b0, len_next}) ? seq_sum - {1'b0, len_next} : seq_sum;
    digit_next = 4'b1111;
    sseg_next  = BLANK;
    if (state_next == RUN) begin
      digit_next = ~(4'b1000 >> pos_next);
      if (seq_idx >= 6'd4) sseg_next = buf_reg[4'(seq_idx - 6'd4)];
    end
  end

  assign digit = digit_reg;
  assign sseg  = sseg_reg;
  assign dp    = 1'b1;
  assign busy  = (state_reg == RUN);
  assign wrap  = wrap_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Scoreboard bench for scroll_display_ctrl: a time-based reference model queues the
// expected outputs for every edge and a monitor compares them after the edge.
module tb_scroll_display_ctrl;

  localparam int RD = 4;
  localparam int SD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [6:0] wr_data = 7'd0;
  logic [4:0] msg_len = 5'd0;
  logic       one_shot = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] digit;
  logic [6:0] sseg;
  logic       dp, busy, wrap, done;

  always #5 clk = ~clk;

  scroll_display_ctrl #(.REFRESH_DIV(RD), .SCROLL_DIV(SD)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .one_shot(one_shot), .start(start), .stop(stop), .pause(pause),
    .digit(digit), .sseg(sseg), .dp(dp), .busy(busy), .wrap(wrap), .done(done)
  );

  typedef struct packed {
    logic [3:0] digit;
    logic [6:0] sseg;
    logic       dp;
    logic       busy;
    logic       wrap;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Reference model: position from elapsed cycles, step after SD whole frames once unpaused.
  bit         m_run = 0;
  bit         m_os = 0;
  int         m_len = 4;
  int         m_cyc = 0;
  int         m_frames = 0;
  int         m_off = 0;
  logic [6:0] m_buf [16];

  task automatic model_step(output obs_t e);
    int p, i;
    e.digit = 4'b1111; e.sseg = 7'h7f; e.dp = 1'b1;
    e.busy = 1'b0; e.wrap = 1'b0; e.done = 1'b0;
    if (!reset) begin
      m_run = 0;
      for (int k = 0; k < 16; k++) m_buf[k] = 7'h7f;
      return;
    end
    if (m_run) begin
      if (stop) m_run = 0;
      else begin
        m_cyc++;
        if (m_cyc == 4 * RD) begin
          m_cyc = 0;
          m_frames++;
          if (m_frames >= SD && !pause) begin
            m_frames = 0;
            m_off = (m_off + 1) % m_len;
            if (m_off == 0) begin
              e.wrap = 1'b1;
              if (m_os) begin
                e.done = 1'b1;
                m_run = 0;
              end
            end
          end
        end
      end
    end else if (start && !stop && msg_len >= 1 && msg_len <= 16) begin
      m_run = 1; m_len = int'(msg_len) + 4; m_os = one_shot;
      m_cyc = 0; m_frames = 0; m_off = 0;
    end
    if (m_run) begin
      p = m_cyc / RD;
      i = (m_off + p) % m_len;
      e.busy  = 1'b1;
      e.digit = 4'(~(4'b1000 >> p));
      e.sseg  = (i < 4) ? 7'h7f : m_buf[i - 4];
    end
    if (wr_en) m_buf[wr_addr] = wr_data;
  endtask

  task automatic tick();
    obs_t e;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [6:0] d);
    $display("[%0t] write buf[%0d]=%b", $time, a, d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len, input logic os, input logic with_stop);
    $display("[%0t] start msg_len=%0d one_shot=%0b stop=%0b", $time, len, os, with_stop);
    start = 1'b1; msg_len = len; one_shot = os; stop = with_stop;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic do_stop();
    $display("[%0t] stop", $time);
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      obs_t e, a;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {digit, sseg, dp, busy, wrap, done};
        cyc++;
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL out_cyc%0d: got digit=%b sseg=%b dp=%b busy=%b wrap=%b done=%b, want digit=%b sseg=%b dp=%b busy=%b wrap=%b done=%b",
                   cyc, a.digit, a.sseg, a.dp, a.busy, a.wrap, a.done,
                   e.digit, e.sseg, e.dp, e.busy, e.wrap, e.done);
        end
      end
    end
  end

  initial begin : stimulus
    for (int k = 0; k < 16; k++) m_buf[k] = 7'h7f;
    #2;
    $display("[%0t] reset held", $time);
    run(3);
    reset = 1'b1;
    $display("[%0t] reset released", $time);
    run(12);

    // Basic looping scroll with a live write to buf[0] while it is on digit 0111.
    do_write(4'd0, 7'b1100011);
    do_write(4'd1, 7'b0000010);
    do_write(4'd2, 7'b0001000);
    do_start(5'd3, 1'b0, 1'b0);
    run(230);
    do_start(5'd9, 1'b1, 1'b0);
    run(250);
    do_write(4'd0, 7'b1101010);
    run(30);
    do_stop();
    run(5);

    // Rejected starts.
    do_start(5'd0, 1'b0, 1'b0);
    run(5);
    do_start(5'd17, 1'b0, 1'b0);
    run(5);
    do_start(5'd3, 1'b0, 1'b1);
    run(5);

    // One-shot pass.
    do_start(5'd3, 1'b1, 1'b0);
    run(240);

    // Pause at offset 2.
    do_start(5'd3, 1'b0, 1'b0);
    run(70);
    $display("[%0t] pause on", $time);
    pause = 1'b1;
    run(100);
    pause = 1'b0;
    $display("[%0t] pause off", $time);
    run(100);
    do_start(5'd5, 1'b0, 1'b0);
    run(6);
    do_stop();
    run(3);

    // Randomized sessions.
    for (int it = 0; it < 12; it++) begin
      for (int w = 0; w < 4; w++) do_write(4'($urandom_range(0, 15)), 7'($urandom));
      do_start(5'($urandom_range(0, 18)), 1'($urandom_range(0, 1)), 1'b0);
      for (int c = 0; c < int'($urandom_range(200, 700)); c++) begin
        if ($urandom_range(0, 29) == 0) pause = ~pause;
        if ($urandom_range(0, 24) == 0) begin
          do_write(4'($urandom_range(0, 15)), 7'($urandom));
        end else if ($urandom_range(0, 149) == 0) begin
          do_start(5'($urandom_range(1, 16)), 1'($urandom_range(0, 1)), 1'b0);
        end else begin
          tick();
        end
      end
      pause = 1'b0;
      do_stop();
    end

    // Reset mid-run: outputs must blank without waiting for an edge.
    do_start(5'd6, 1'b0, 1'b0);
    run(40);
    $display("[%0t] async reset mid-run", $time);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({digit, sseg, busy, wrap, done} !== {4'b1111, 7'h7f, 3'b000}) begin
      n_fail++;
      $display("FAIL async_reset: got digit=%b sseg=%b busy=%b wrap=%b done=%b, want 1111 1111111 0 0 0",
               digit, sseg, busy, wrap, done);
    end
    #1;
    run(3);
    reset = 1'b1;
    $display("[%0t] reset released", $time);
    run(10);
    do_start(5'd16, 1'b1, 1'b0);
    run(650);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
